// File: rtl/jk_cmd_driver.sv
// Command stage for a downstream JK flop: a valid/ready FIFO that feeds registered j/k outputs.
// It also keeps a model of the flop's q. Define JK_DRV_CHECK_EN to compare q_fb against that model.
module jk_cmd_driver #(
  parameter int DEPTH = 4,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cmd_valid,
  input  logic [1:0]       cmd,
  output logic             cmd_ready,
  input  logic             flush,
  output logic             j,
  output logic             k,
  input  logic             q_fb,
  output logic             q_model,
  output logic             busy,
  output logic [CNT_W-1:0] issued,
  output logic             mismatch
);
  // Handshake: a command transfers on an edge where cmd_valid & cmd_ready are both high.
  // cmd_ready depends only on occupancy, flush and rst, never on cmd_valid.
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_OCC = (AW+1)'(DEPTH);

  logic [1:0]    mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [AW:0]   occ;
  logic          push;
  logic          pop;
  logic          q_next;

  assign cmd_ready = !rst && (occ != FULL_OCC) && !flush;
  assign push      = cmd_valid && cmd_ready;
  assign pop       = (occ != '0) && !flush;
  assign busy      = (occ != '0) || j || k;

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= cmd;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      occ    <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      occ    <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      if (push && !pop)      occ <= occ + 1'b1;
      else if (pop && !push) occ <= occ - 1'b1;
    end
  end

  // The model advances from the j/k the flop sees on this same edge.
  always_comb begin
    q_next = q_model;
    case ({j, k})
      2'b01:   q_next = 1'b0;
      2'b10:   q_next = 1'b1;
      2'b11:   q_next = ~q_model;
      default: q_next = q_model;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      j       <= 1'b0;
      k       <= 1'b0;
      q_model <= 1'b0;
      issued  <= '0;
    end else begin
      q_model <= q_next;
      if (pop) begin
        {j, k} <= mem[rd_ptr];
        issued <= issued + 1'b1;
      end else begin
        {j, k} <= 2'b00;
      end
    end
  end

`ifdef JK_DRV_CHECK_EN
  // chk_arm waits one edge after reset so the flop's sync reset has cleared q.
  logic chk_arm;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      chk_arm  <= 1'b0;
      mismatch <= 1'b0;
    end else begin
      chk_arm <= 1'b1;
      if (chk_arm && (q_fb != q_model)) mismatch <= 1'b1;
    end
  end
`else
  logic unused_q_fb;
  assign unused_q_fb = q_fb;
  assign mismatch    = 1'b0;
`endif
endmodule

// File: tb/tb_jk_cmd_driver.sv
// Directed bench for jk_cmd_driver with a behavioural JK flop closing the q_fb loop.
module tb_jk_cmd_driver;
  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       cmd_valid = 1'b0;
  logic [1:0] cmd = 2'b00;
  logic       cmd_ready;
  logic       flush = 1'b0;
  logic       j, k;
  logic       q_fb;
  logic       q_model;
  logic       busy;
  logic [7:0] issued;
  logic       mismatch;

  logic       flop_q = 1'b0;
  logic       inv = 1'b0;
  int         nvec = 0;
  int         nerr = 0;

  always #5 clk = ~clk;

  // Reference JK flop: sync reset, posedge, same j/k as the DUT's model.
  always @(posedge clk) begin
    if (rst) flop_q <= 1'b0;
    else begin
      case ({j, k})
        2'b01:   flop_q <= 1'b0;
        2'b10:   flop_q <= 1'b1;
        2'b11:   flop_q <= ~flop_q;
        default: flop_q <= flop_q;
      endcase
    end
  end
  assign q_fb = flop_q ^ inv;

  jk_cmd_driver #(.DEPTH(4), .CNT_W(8)) dut (
    .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd(cmd), .cmd_ready(cmd_ready),
    .flush(flush), .j(j), .k(k), .q_fb(q_fb), .q_model(q_model), .busy(busy),
    .issued(issued), .mismatch(mismatch)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nvec++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic do_reset();
    #2 rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    tick();
  endtask

  initial begin
    // Power-on reset, checked before any edge
    #2 rst = 1'b1;
    #1;
    chk("por_ready", cmd_ready, 0);
    chk("por_jk", {j, k}, 2'b00);
    chk("por_qm", q_model, 0);
    chk("por_issued", issued, 0);
    tick();
    rst = 1'b0;
    tick();
    chk("idle_ready", cmd_ready, 1);
    chk("idle_busy", busy, 0);

    // Back-to-back sequence 00,01,10,11,11
    cmd_valid = 1'b1; cmd = 2'b00; tick();
    chk("seq_busy_q", busy, 1);
    chk("seq_jk_lat", {j, k}, 2'b00);
    chk("seq_iss0", issued, 0);
    cmd = 2'b01; tick();
    chk("seq_jk1", {j, k}, 2'b00);
    chk("seq_iss1", issued, 1);
    chk("seq_ready_stream", cmd_ready, 1);
    cmd = 2'b10; tick();
    chk("seq_jk2", {j, k}, 2'b01);
    chk("seq_qm2", q_model, 0);
    cmd = 2'b11; tick();
    chk("seq_jk3", {j, k}, 2'b10);
    chk("seq_qm3", q_model, 0);
    cmd = 2'b11; tick();
    chk("seq_jk4", {j, k}, 2'b11);
    chk("seq_qm4", q_model, 1);
    cmd_valid = 1'b0; tick();
    chk("seq_jk5", {j, k}, 2'b11);
    chk("seq_qm5", q_model, 0);
    chk("seq_iss5", issued, 5);
    tick();
    chk("seq_jk_done", {j, k}, 2'b00);
    chk("seq_qm_done", q_model, 1);
    chk("seq_busy_done", busy, 0);
    chk("seq_iss_done", issued, 5);
`ifdef JK_DRV_CHECK_EN
    chk("chk_clean", mismatch, 0);
    inv = 1'b1; tick();
    inv = 1'b0;
    chk("chk_hit", mismatch, 1);
    tick(); tick();
    chk("chk_sticky", mismatch, 1);
`else
    inv = 1'b1; tick();
    inv = 1'b0;
    chk("nochk_tied", mismatch, 0);
    tick(); tick();
`endif

    // Reset mid-cycle with live state
    cmd_valid = 1'b1; cmd = 2'b10; tick();
    #2 rst = 1'b1;
    #1;
    chk("mid_ready", cmd_ready, 0);
    chk("mid_qm", q_model, 0);
    chk("mid_issued", issued, 0);
    chk("mid_busy", busy, 0);
    chk("mid_mismatch", mismatch, 0);
    cmd_valid = 1'b0;
    tick();
    rst = 1'b0;
    tick();
    chk("mid_queue_lost", busy, 0);

    // Flush with three queued commands and a refused push
    cmd_valid = 1'b1; cmd = 2'b10; tick();
    cmd = 2'b10; tick();
    cmd = 2'b01; tick();
    chk("fl_pre_jk", {j, k}, 2'b10);
    chk("fl_pre_qm", q_model, 1);
    chk("fl_pre_iss", issued, 2);
    flush = 1'b1; cmd = 2'b01;
    #1;
    chk("fl_ready", cmd_ready, 0);
    tick();
    flush = 1'b0; cmd_valid = 1'b0;
    chk("fl_jk", {j, k}, 2'b00);
    chk("fl_busy", busy, 0);
    chk("fl_qm", q_model, 1);
    tick();
    chk("fl_refused_jk", {j, k}, 2'b00);
    chk("fl_refused_iss", issued, 2);
    chk("fl_qm_hold", q_model, 1);
    chk("fl_sticky_ok", mismatch, 0);

    // Counter wrap after 256 issued commands
    do_reset();
    cmd_valid = 1'b1; cmd = 2'b00;
    for (int i = 0; i < 256; i++) tick();
    cmd_valid = 1'b0;
    chk("wrap_255", issued, 255);
    tick();
    chk("wrap_0", issued, 0);
    chk("wrap_busy", busy, 0);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule
